layer_ram_sdp: RTL and testbench

- Simple dual-port layer buffer: port A write-only, port B read-only, both on one clock.
- Holds one feature-map layer of 16-bit floating-point values loaded from the host (PCIe) stream.
- Downstream convolution logic reads the values back by address.
- Synthesisable as inferred block RAM; contents are opaque bits, with no arithmetic on data.

---
 rtl/layer_pkg.sv | 14 +
 rtl/layer_ram_outreg.sv | 20 ++
 rtl/layer_ram_sdp.sv | 76 +++++++
 tb/tb_layer_ram_sdp.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared layer-buffer constants: fp16 word width and layer address space,
// used by the loader, the conv engines and the layer RAM.
package layer_pkg;

  localparam int LAYER_DATA_W = 16;
  localparam int LAYER_ADDR_W = 19;
  localparam int LAYER_DEPTH  = 2 ** LAYER_ADDR_W;

  // Index width needed to address 'depth' words; never below 1 bit.
  function automatic int mem_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_ram_outreg.sv
// Port-B pipeline register: async active-low clear, load on enable.
module layer_ram_outreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/layer_ram_sdp.sv
// Simple dual-port layer buffer: write-only port A, read-only port B, one clock.
// Read-first on address collision; out-of-range writes dropped, reads return 0.
module layer_ram_sdp
  import layer_pkg::*;
#(
  parameter int DATA_W  = LAYER_DATA_W,
  parameter int ADDR_W  = LAYER_ADDR_W,
  parameter int DEPTH   = LAYER_DEPTH,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  localparam int               MEM_AW    = mem_aw(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_q;

  assign wr_ok = ena && wea && ({1'b0, addra} < DEPTH_LIM);
  assign rd_ok = ({1'b0, addrb} < DEPTH_LIM);

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[addra[MEM_AW-1:0]] <= dina;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[addrb[MEM_AW-1:0]];
    end
  end

  layer_ram_outreg #(
    .W (DATA_W)
  ) u_rd_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enb),
    .d     (rd_word),
    .q     (rd_q)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Free-running second stage: only the first stage honours enb.
      layer_ram_outreg #(
        .W (DATA_W)
      ) u_out_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (rd_q),
        .q     (doutb)
      );
    end else begin : g_no_out_reg
      assign doutb = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_layer_ram_sdp.sv
// Self-checking bench: latency-1 and latency-2 instances driven in parallel.
module tb_layer_ram_sdp;

  localparam int DW    = 16;
  localparam int AW    = 19;
  localparam int DEPTH = 1000;
  localparam int NV    = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, wea, enb;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina;
  logic [DW-1:0] doutb1, doutb2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic          ck;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] exp;
    int            due;
  } sb_t;

  vec_t tbl [NV];
  sb_t  q [$];

  always #5 clk = ~clk;

  layer_ram_sdp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .OUT_REG(0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb1)
  );

  layer_ram_sdp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .OUT_REG(1)) u_l2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb2)
  );

  function automatic vec_t v(input int e_a, input int w_a, input int a_a, input int d_a,
                             input int e_b, input int a_b, input int ck, input int ex);
    vec_t r;
    r.ena   = 1'(e_a);
    r.wea   = 1'(w_a);
    r.addra = AW'(a_a);
    r.dina  = DW'(d_a);
    r.enb   = 1'(e_b);
    r.addrb = AW'(a_b);
    r.ck    = 1'(ck);
    r.exp   = DW'(ex);
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // row: ena wea addra dina enb addrb check expected_doutb(latency 1)
    tbl[0]  = v(1, 1, 0,      'h3C00, 0, 0,      1, 'h0000);
    tbl[1]  = v(1, 1, 1,      'h4000, 0, 0,      1, 'h0000);
    tbl[2]  = v(1, 1, 2,      'h4200, 1, 0,      1, 'h3C00);
    tbl[3]  = v(0, 0, 0,      'h0000, 1, 1,      1, 'h4000);
    tbl[4]  = v(0, 0, 0,      'h0000, 1, 2,      1, 'h4200);
    tbl[5]  = v(1, 1, 5,      'h1111, 1, 1,      1, 'h4000);
    tbl[6]  = v(1, 1, 5,      'h2222, 1, 5,      1, 'h1111);
    tbl[7]  = v(0, 0, 0,      'h0000, 1, 5,      1, 'h2222);
    tbl[8]  = v(1, 0, 1,      'hFFFF, 1, 2,      1, 'h4200);
    tbl[9]  = v(0, 1, 1,      'hFFFF, 1, 1,      1, 'h4000);
    tbl[10] = v(0, 0, 0,      'h0000, 1, 1,      1, 'h4000);
    tbl[11] = v(0, 0, 0,      'h0000, 0, 5,      1, 'h4000);
    tbl[12] = v(0, 0, 0,      'h0000, 0, 2,      1, 'h4000);
    tbl[13] = v(1, 1, 999,    'hABCD, 1, 0,      1, 'h3C00);
    tbl[14] = v(0, 0, 0,      'h0000, 1, 999,    1, 'hABCD);
    tbl[15] = v(1, 1, 1000,   'h5555, 1, 1000,   1, 'h0000);
    tbl[16] = v(1, 1, 1024,   'h7777, 1, 999,    1, 'hABCD);
    tbl[17] = v(0, 0, 0,      'h0000, 1, 0,      1, 'h3C00);
    tbl[18] = v(0, 0, 0,      'h0000, 1, 524287, 1, 'h0000);
    tbl[19] = v(0, 0, 0,      'h0000, 1, 2,      1, 'h4200);

    rst_n = 1'b0;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    enb   = 1'b1;
    addrb = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_l1", doutb1, 16'h0000);
      check("rst_hold_l2", doutb2, 16'h0000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    enb   = 1'b0;
    #1;
    check("rst_release_l1", doutb1, 16'h0000);
    check("rst_release_l2", doutb2, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ena   = tbl[i].ena;
      wea   = tbl[i].wea;
      addra = tbl[i].addra;
      dina  = tbl[i].dina;
      enb   = tbl[i].enb;
      addrb = tbl[i].addrb;
      @(posedge clk);
      #1;
      cyc++;
      if (tbl[i].ck) begin
        check($sformatf("vec%0d_l1", i), doutb1, tbl[i].exp);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        sb_t s;
        s = q.pop_front();
        check($sformatf("vec%0d_l2", i), doutb2, s.exp);
      end
      if (tbl[i].ck) begin
        q.push_back('{exp: tbl[i].exp, due: cyc + 1});
      end
    end

    // Async clear mid read stream, well before the next clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_l1", doutb1, 16'h0000);
    check("rst_async_l2", doutb2, 16'h0000);
    q.delete();

    @(negedge clk);
    rst_n = 1'b1;
    enb   = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_l1", doutb1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
